// File: rtl/pipe_stage_buffer_pkg.sv
// Shared types for the pipeline stage buffer: occupancy states and encodings.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/pipe_stage_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush, upstream hold and stall/bubble performance counters.
module pipe_stage_buffer
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              hold,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  bubble_count
);

  stage_state_t      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              push, pop;

  always_comb begin
    if (SKID != 0) begin
      in_ready = ~hold & (state_q != TWO);
    end else begin
      in_ready = ~hold & ((state_q == EMPTY) | out_ready);
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Only validity clears; payload registers keep stale contents.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end else if (push && (SKID != 0)) begin
            skid_d  = in_data;
            state_d = TWO;
          end
        end
        TWO: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    case (state_q)
      ONE:     occupancy = OCC_ONE;
      TWO:     occupancy = OCC_TWO;
      default: occupancy = OCC_EMPTY;
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr   (cnt_clr),
    .inc   (out_valid & ~out_ready),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr   (cnt_clr),
    .inc   (out_ready & ~out_valid),
    .count (bubble_count)
  );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: queue-based reference model, directed vector
// table, hand-written corner sequences and randomized traffic.
module tb_pipe_stage_buffer;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              hold;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic              cnt_clr;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  bubble_count;

  pipe_stage_buffer #(.DATA_W(DATA_W), .SKID(1), .CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .hold         (hold),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .cnt_clr      (cnt_clr),
    .stall_count  (stall_count),
    .bubble_count (bubble_count)
  );

  always #5 CLK = ~CLK;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: an ordered queue of held payloads (capacity 2) plus counts.
  logic [DATA_W-1:0] mq[$];
  int m_stall  = 0;
  int m_bubble = 0;
  logic rdy_pre;

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] d;
    logic              h;
    logic              fl;
    logic              ordy;
    logic              clr;
    logic              e_rdy;
    logic              e_valid;
    logic [DATA_W-1:0] e_data;
    logic [1:0]        e_occ;
    logic [CNT_W-1:0]  e_stall;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic iv, logic [DATA_W-1:0] d, logic h, logic fl,
                              logic ordy, logic clr, logic e_rdy, logic e_valid,
                              logic [DATA_W-1:0] e_data, logic [1:0] e_occ,
                              logic [CNT_W-1:0] e_stall);
    vec_t v;
    v.iv = iv; v.d = d; v.h = h; v.fl = fl; v.ordy = ordy; v.clr = clr;
    v.e_rdy = e_rdy; v.e_valid = e_valid; v.e_data = e_data;
    v.e_occ = e_occ; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: drive at negedge, check pre-edge outputs, update model, check post-edge.
  task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic h,
                      input logic fl, input logic ordy, input logic clr);
    bit mv, push, pop;
    @(negedge CLK);
    in_valid = iv; in_data = d; hold = h; flush = fl; out_ready = ordy; cnt_clr = clr;
    #1;
    mv      = (mq.size() != 0);
    rdy_pre = in_ready;
    check("in_ready", in_ready, 32'(!h && mq.size() < 2));
    check("out_valid_pre", out_valid, 32'(mv));
    push = iv && !h && (mq.size() < 2);
    pop  = mv && ordy;
    if (clr) begin
      m_stall = 0; m_bubble = 0;
    end else begin
      if (mv && !ordy && m_stall < SAT) m_stall++;
      if (!mv && ordy && m_bubble < SAT) m_bubble++;
    end
    if (fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(d);
    end
    @(posedge CLK);
    #1;
    check("out_valid", out_valid, 32'(mq.size() != 0));
    check("occupancy", occupancy, 32'(mq.size()));
    if (mq.size() != 0) check("out_data", out_data, mq[0]);
    check("stall_count", stall_count, 32'(m_stall));
    check("bubble_count", bubble_count, 32'(m_bubble));
  endtask

  initial begin
    int st;
    nRST = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    hold = 1'b0; flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_stall", stall_count, 0);
    check("rst_bubble", bubble_count, 0);
    @(negedge CLK);
    nRST = 1'b1; in_valid = 1'b0;

    step(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("first_push_valid", out_valid, 1);
    check("first_push_data", out_data, 32'h1);

    // Streaming at full throughput.
    st = m_stall;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h10 + i, 1'b0, 1'b0, 1'b1, 1'b0);
      check("stream_in_ready", rdy_pre, 1);
      check("stream_data", out_data, 32'h10 + i);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("stream_stall", stall_count, 32'(st));

    // Empty the stage and zero counters before the directed table.
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);

    tbl[0]  = mk(1, 32'hA, 0, 0, 0, 0,  1, 1, 32'hA, 1, 0);
    tbl[1]  = mk(1, 32'hB, 0, 0, 0, 0,  1, 1, 32'hA, 2, 1);
    tbl[2]  = mk(0, 32'h0, 0, 0, 0, 0,  0, 1, 32'hA, 2, 2);
    tbl[3]  = mk(0, 32'h0, 0, 0, 0, 0,  0, 1, 32'hA, 2, 3);
    tbl[4]  = mk(0, 32'h0, 0, 0, 1, 0,  0, 1, 32'hB, 1, 3);
    tbl[5]  = mk(0, 32'h0, 0, 0, 1, 0,  1, 0, 32'h0, 0, 3);
    tbl[6]  = mk(1, 32'hC, 0, 0, 0, 0,  1, 1, 32'hC, 1, 3);
    tbl[7]  = mk(1, 32'hD, 0, 0, 0, 0,  1, 1, 32'hC, 2, 4);
    tbl[8]  = mk(1, 32'hE, 0, 1, 0, 0,  0, 0, 32'h0, 0, 5);
    tbl[9]  = mk(1, 32'hF, 0, 0, 1, 0,  1, 1, 32'hF, 1, 5);
    tbl[10] = mk(1, 32'h7, 1, 0, 1, 0,  0, 0, 32'h0, 0, 5);
    tbl[11] = mk(1, 32'h8, 1, 0, 1, 0,  0, 0, 32'h0, 0, 5);
    tbl[12] = mk(1, 32'h9, 0, 1, 1, 0,  1, 0, 32'h0, 0, 5);
    tbl[13] = mk(0, 32'h0, 0, 0, 1, 1,  1, 0, 32'h0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].h, tbl[i].fl, tbl[i].ordy, tbl[i].clr);
      check($sformatf("tbl%0d_in_ready", i), rdy_pre, tbl[i].e_rdy);
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d_occupancy", i), occupancy, tbl[i].e_occ);
      check($sformatf("tbl%0d_stall", i), stall_count, tbl[i].e_stall);
      if (tbl[i].e_valid) check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_data);
    end

    // Stall counter saturation, then clear.
    step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stall_saturated", stall_count, 15);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("stall_cleared", stall_count, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 29) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
